// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the fifo write arbiter slice: width macro and rotation helper.
// Optional build macro used by this slice: FIFO_WRITE_ARBITER_PRIORITY_EN.
`ifndef CLOG2
`define CLOG2(x) ($clog2(x))
`endif

package fifo_write_arbiter_pkg;

    // Wrap a rotated requester index back into 0..n-1 (idx never exceeds 2n-1).
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last+1, wrapping.
// Produces a one-hot grant and its binary index; all zero when disabled or idle.
module fifo_arb_rr_pick
    import fifo_write_arbiter_pkg::*;
#(
    parameter int REQ = 4,
    parameter int IW  = `CLOG2(REQ)
) (
    input  logic [REQ-1:0] req,
    input  logic [IW-1:0]  last,
    input  logic           enable,
    output logic [REQ-1:0] grant,
    output logic [IW-1:0]  index
);

    logic          found;
    int            cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        grant    = '0;
        index    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= REQ; k++) begin
            cand     = rr_wrap(int'(last) + k, REQ);
            cand_idx = IW'(cand);
            if (enable && !found && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                index           = cand_idx;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Arbitrates REQ requesters onto one fifo write port and tracks downstream occupancy.
// Define FIFO_WRITE_ARBITER_PRIORITY_EN to give requester 0 strict priority over the rotation.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NUM   = 256,
    parameter int REQ   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REQ-1:0]       req,
    input  logic [REQ*WIDTH-1:0] req_data,
    output logic [REQ-1:0]       grant,
    output logic [WIDTH-1:0]     fifo_write_data,
    output logic                 fifo_write_strobe,
    input  logic                 fifo_read_strobe,
    output logic [`CLOG2(NUM):0] fifo_level,
    output logic                 fifo_full
);

    localparam int LW = `CLOG2(NUM) + 1;
    localparam int IW = `CLOG2(REQ);

    logic [IW-1:0]    last;
    logic [IW-1:0]    rr_idx;
    logic [IW-1:0]    win_idx;
    logic [REQ-1:0]   rr_req;
    logic [REQ-1:0]   rr_grant;
    logic             arb_en;
    logic             rr_en;
    logic             grant_any;
    logic             last_upd;
    logic [WIDTH-1:0] win_data;

    // One slot is kept empty so the fifo pointers can tell full from empty.
    assign fifo_full = (fifo_level == LW'(NUM - 1));
    assign arb_en    = !reset && !fifo_full;

`ifdef FIFO_WRITE_ARBITER_PRIORITY_EN
    assign rr_req   = {req[REQ-1:1], 1'b0};
    assign rr_en    = arb_en && !req[0];
    assign grant    = (arb_en && req[0]) ? REQ'(1) : rr_grant;
    assign win_idx  = req[0] ? '0 : rr_idx;
    assign last_upd = |rr_grant;
`else
    assign rr_req   = req;
    assign rr_en    = arb_en;
    assign grant    = rr_grant;
    assign win_idx  = rr_idx;
    assign last_upd = |rr_grant;
`endif

    fifo_arb_rr_pick #(
        .REQ (REQ),
        .IW  (IW)
    ) u_pick (
        .req    (rr_req),
        .last   (last),
        .enable (rr_en),
        .grant  (rr_grant),
        .index  (rr_idx)
    );

    assign grant_any = |grant;
    assign win_data  = req_data[win_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_level        <= '0;
            fifo_write_strobe <= 1'b0;
            fifo_write_data   <= '0;
            last              <= IW'(REQ - 1);
        end else begin
            fifo_write_strobe <= grant_any;
            if (grant_any) begin
                fifo_write_data <= win_data;
            end
            if (last_upd) begin
                last <= win_idx;
            end
            if (grant_any && !fifo_read_strobe) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (!grant_any && fifo_read_strobe && (fifo_level != '0)) begin
                fifo_level <= fifo_level - LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (WIDTH=8, NUM=8, REQ=4) with a write-data scoreboard.
// Expectations adapt when FIFO_WRITE_ARBITER_PRIORITY_EN is defined.
module tb_fifo_write_arbiter;

    localparam int WIDTH = 8;
    localparam int NUM   = 8;
    localparam int REQ   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [7:0]  fifo_write_data;
    logic        fifo_write_strobe;
    logic        fifo_read_strobe;
    logic [3:0]  fifo_level;
    logic        fifo_full;

    int         errors = 0;
    int         checks = 0;
    int         exp_level = 0;
    int         word_ctr = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .WIDTH (WIDTH),
        .NUM   (NUM),
        .REQ   (REQ)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req               (req),
        .req_data          (req_data),
        .grant             (grant),
        .fifo_write_data   (fifo_write_data),
        .fifo_write_strobe (fifo_write_strobe),
        .fifo_read_strobe  (fifo_read_strobe),
        .fifo_level        (fifo_level),
        .fifo_full         (fifo_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check combinational outputs mid-cycle, then the registered write side.
    task automatic step(input string tag, input logic [3:0] exp_g);
        logic pushed;
        int   gi;
        pushed = 1'b0;
        gi     = 0;
        @(negedge clk);
        chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
        chk({tag, "_level"}, 32'(fifo_level), 32'(exp_level));
        chk({tag, "_full"}, 32'(fifo_full), 32'(exp_level == NUM - 1));
        if (exp_g != 4'b0000) begin
            for (int i = 0; i < REQ; i++) if (exp_g[i]) gi = i;
            sb.push_back(req_data[gi*8 +: 8]);
            pushed = 1'b1;
        end
        if (reset) exp_level = 0;
        else if (pushed && !fifo_read_strobe) exp_level++;
        else if (!pushed && fifo_read_strobe && exp_level > 0) exp_level--;
        @(posedge clk);
        #1;
        if (pushed) begin
            chk({tag, "_wstrobe"}, 32'(fifo_write_strobe), 32'd1);
            chk({tag, "_wdata"}, 32'(fifo_write_data), 32'(sb.pop_front()));
            word_ctr++;
            req_data[gi*8 +: 8] = 8'(gi * 64 + word_ctr);
        end else begin
            chk({tag, "_wstrobe"}, 32'(fifo_write_strobe), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset            = 1'b1;
        req              = 4'b1111;
        req_data         = 32'h44332211;
        fifo_read_strobe = 1'b0;
        @(posedge clk);
        #1;

        // Requests held through reset are ignored; then round-robin from requester 0.
        step("rst0", 4'b0000);
        step("rst1", 4'b0000);
        chk("rst_wdata", 32'(fifo_write_data), 32'd0);
        reset = 1'b0;
        step("rr0", 4'b0001);
        step("rr1", 4'b0010);
        step("rr2", 4'b0100);
        step("rr3", 4'b1000);
        step("rr4", 4'b0001);

        // Reset while requesting: grant suppressed, occupancy cleared, no write.
        reset = 1'b1;
        step("rst2", 4'b0000);
        reset = 1'b0;

        // Rotation skips idle requesters.
        req = 4'b1111;
        step("sk0", 4'b0001);
        step("sk1", 4'b0010);
        req = 4'b1001;
        step("sk2", 4'b1000);
        step("sk3", 4'b0001);
        step("sk4", 4'b1000);
        req = 4'b0000;
        step("idle", 4'b0000);

        // Drain to level 3, then grant and read together, then read at level 0.
        fifo_read_strobe = 1'b1;
        step("rd0", 4'b0000);
        step("rd1", 4'b0000);
        req = 4'b0100;
        step("gr_rd", 4'b0100);
        req = 4'b0000;
        step("rd2", 4'b0000);
        step("rd3", 4'b0000);
        step("rd4", 4'b0000);
        step("rd_zero", 4'b0000);
        fifo_read_strobe = 1'b0;
        step("zero", 4'b0000);

        // Fill to NUM-1 with requester 2, then release with one read.
        reset = 1'b1;
        step("rst3", 4'b0000);
        reset = 1'b0;
        req = 4'b0100;
        for (int i = 0; i < NUM - 1; i++) step("fill", 4'b0100);
        step("full0", 4'b0000);
        step("full1", 4'b0000);
        fifo_read_strobe = 1'b1;
        step("rel_rd", 4'b0000);
        fifo_read_strobe = 1'b0;
        step("rel_gr", 4'b0100);
        step("refull", 4'b0000);

        // All requesting: strict priority or plain rotation depending on build.
        reset = 1'b1;
        step("rst4", 4'b0000);
        reset = 1'b0;
        req = 4'b1111;
`ifdef FIFO_WRITE_ARBITER_PRIORITY_EN
        step("pr0", 4'b0001);
        step("pr1", 4'b0001);
        step("pr2", 4'b0001);
        step("pr3", 4'b0001);
`else
        step("pr0", 4'b0001);
        step("pr1", 4'b0010);
        step("pr2", 4'b0100);
        step("pr3", 4'b1000);
`endif
        req = 4'b1110;
        step("pr4", 4'b0010);
        step("pr5", 4'b0100);
        step("pr6", 4'b1000);
        step("pr_full", 4'b0000);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter NUM, default 256, depth of the downstream fifo; power of two, 4..65536.
REQ-003 SHALL have parameter REQ, default 4, number of requesters; 2..8.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req  in  REQ  bit i high: requester i presents a word.
REQ-007 SHALL have port req_data  in  REQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port grant  out  REQ  one-hot or zero; combinational; bit i high: requester i's word is accepted this cycle.
REQ-009 SHALL have port fifo_write_data  out  WIDTH  registered word to the fifo write port.
REQ-010 SHALL have port fifo_write_strobe  out  1  registered fifo write strobe.
REQ-011 SHALL have port fifo_read_strobe  in  1  copy of the consumer's fifo read strobe, used for occupancy tracking.
REQ-012 SHALL have port fifo_level  out  CLOG2(NUM)+1  registered count of words granted and not yet read.
REQ-013 SHALL have port fifo_full  out  1  high when fifo_level == NUM-1.

Function
REQ-014 SHALL assert no grant bit while fifo_full is high, regardless of req.
REQ-015 SHALL, when not full and req != 0, assert exactly one grant bit: the first set req bit found by searching upward from (last+1) mod REQ, wrapping.
REQ-016 SHALL update last to the granted index at the posedge following a grant; last is unchanged in cycles with no grant.
REQ-017 SHALL, at the posedge ending a grant cycle, load fifo_write_data with the granted word and set fifo_write_strobe to 1, giving write latency 1 cycle.
REQ-018 SHALL clear fifo_write_strobe at each posedge with no grant; fifo_write_data holds its value.
REQ-019 SHALL never assert grant for a requester whose req bit is low.
REQ-020 SHALL treat the handshake as follows: the requester holds req and data stable until it sees grant; a requester still requesting after grant presents its next word.
REQ-021 SHALL update fifo_level at each posedge:
- +1 on grant only.
- -1 on fifo_read_strobe only, when level > 0.
- unchanged when a grant and a read strobe coincide.
- unchanged on a read strobe at level 0.
REQ-022 SHALL cap usable capacity at NUM-1 words, because equal fifo pointers mean empty; a grant in the cycle that makes level NUM-1 is permitted.
REQ-023 SHALL compute fifo_full from registered fifo_level, so a read strobe while full enables grants from the next cycle.

Reset
REQ-024 SHALL, when reset is sampled high, drive:
- fifo_level = 0
- fifo_full = 0
- fifo_write_strobe = 0
- fifo_write_data = 0
- last = REQ-1, so requester 0 wins first.
REQ-025 SHALL force grant to 0 combinationally while reset is high, discarding any in-flight request; a write registered before reset is dropped.

Configuration
REQ-026 SHALL, when FIFO_WRITE_ARBITER_PRIORITY_EN is defined, give requester 0 strict priority: req[0] is granted whenever not full; round-robin applies only among requesters 1..REQ-1; last tracks only those indices.
REQ-027 SHALL, when FIFO_WRITE_ARBITER_PRIORITY_EN is undefined, use pure round-robin over all REQ requesters as in REQ-015.

Structure
REQ-028 SHALL take the CLOG2 width macro from the shared utility header; no local width functions.
REQ-029 SHALL implement the rotating search in one combinational sub-module, fifo_arb_rr_pick, with inputs req, last and enable, and outputs a one-hot grant and a binary index.
REQ-030 SHALL keep the occupancy counter and output registers in the top module; no further sub-modules.

Verification
REQ-031 SHALL cover the reset scenario: req=4'b1111 held during and after reset -> grant=0 during reset; grants 0,1,2,3,0 on the following 5 cycles.
REQ-032 SHALL cover rotation skipping: after a grant to 1, req=4'b1001 -> grant to 3, then 0, then 3.
REQ-033 SHALL cover the full boundary with NUM=8, no reads, req[2] constant: exactly 7 grants; fifo_full=1; grant=0 thereafter.
REQ-034 SHALL cover release from full: while full, one fifo_read_strobe -> level 6 next cycle; grant the cycle after that; level back to 7.
REQ-035 SHALL cover simultaneous events: a grant and a read strobe in the same cycle at level 3 -> level stays 3; a read strobe at level 0 -> level stays 0.
REQ-036 SHALL cover priority with FIFO_WRITE_ARBITER_PRIORITY_EN defined, req=4'b1111 for 4 cycles -> grant=0001 every cycle; with req[0] dropped -> grants 1,2,3 in order.
